// File: rtl/matrix_write_assembler.sv
// rtl/matrix_write_assembler.sv - serial-to-parallel matrix assembler for the storage write port
//
// Collects row*col elements over a valid/ready handshake into a zero-filled
// buffer and issues one parallel write to a round-robin storage slot.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, row_in, col_in  begin a matrix with the given dimensions (IDLE only)
//   abort                  drop the matrix being loaded, no write
//   in_valid, in_data      element stream, row-major
//   in_ready               element accepted on in_valid & in_ready
//   wr_en, target_idx      one-cycle write strobe and destination slot
//   write_row, write_col   latched dimensions of the written matrix
//   data_flat              element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   elem_cnt               elements accepted for the current matrix
//   busy, done, dim_err    status: loading/committing, write finished, bad dimensions
module matrix_write_assembler #(
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_SIZE     = 5,
    parameter int MATRIX_NUM   = 8,
    parameter int MATRIX_IDX_W = 3
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [2:0]                            row_in,
    input  logic [2:0]                            col_in,
    input  logic                                  abort,
    input  logic                                  in_valid,
    input  logic [DATA_WIDTH-1:0]                 in_data,
    output logic                                  in_ready,
    output logic                                  wr_en,
    output logic [MATRIX_IDX_W-1:0]               target_idx,
    output logic [2:0]                            write_row,
    output logic [2:0]                            write_col,
    output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] data_flat,
    output logic [4:0]                            elem_cnt,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  dim_err
);

    localparam int DEPTH = MAX_SIZE * MAX_SIZE;
    localparam logic [2:0] MAX_DIM = 3'(MAX_SIZE);
    localparam logic [MATRIX_IDX_W-1:0] LAST_SLOT = MATRIX_IDX_W'(MATRIX_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   buffer [DEPTH];
    logic [4:0]              total;
    logic [MATRIX_IDX_W-1:0] alloc_ptr;
    logic                    dims_ok;
    logic                    last_elem;

    assign dims_ok   = (row_in != 3'd0) && (row_in <= MAX_DIM) &&
                       (col_in != 3'd0) && (col_in <= MAX_DIM);
    assign last_elem = (elem_cnt == total - 5'd1);

    for (genvar k = 0; k < DEPTH; k++) begin : g_flat
        assign data_flat[k*DATA_WIDTH +: DATA_WIDTH] = buffer[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dim_err    <= 1'b0;
            target_idx <= '0;
            alloc_ptr  <= '0;
            elem_cnt   <= '0;
            total      <= '0;
            write_row  <= 3'd1;
            write_col  <= 3'd1;
            for (int i = 0; i < DEPTH; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            wr_en   <= 1'b0;
            done    <= 1'b0;
            dim_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (dims_ok) begin
                            write_row <= row_in;
                            write_col <= col_in;
                            total     <= {2'b00, row_in} * {2'b00, col_in};
                            elem_cnt  <= '0;
                            // Clearing here is what guarantees unused slots read 0.
                            for (int i = 0; i < DEPTH; i++) begin
                                buffer[i] <= '0;
                            end
                            in_ready  <= 1'b1;
                            busy      <= 1'b1;
                            state     <= S_LOAD;
                        end else begin
                            dim_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    // Abort wins over a same-cycle handshake; that element is lost.
                    if (abort) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (in_valid && in_ready) begin
                        buffer[elem_cnt] <= in_data;
                        elem_cnt         <= elem_cnt + 5'd1;
                        if (last_elem) begin
                            in_ready   <= 1'b0;
                            wr_en      <= 1'b1;
                            target_idx <= alloc_ptr;
                            state      <= S_COMMIT;
                        end
                    end
                end
                S_COMMIT: begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    alloc_ptr <= (alloc_ptr == LAST_SLOT) ? '0 : alloc_ptr + 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_write_assembler.sv
// tb/tb_matrix_write_assembler.sv - scoreboard bench for matrix_write_assembler
module tb_matrix_write_assembler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   row_in;
    logic [2:0]   col_in;
    logic         abort;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         wr_en;
    logic [2:0]   target_idx;
    logic [2:0]   write_row;
    logic [2:0]   write_col;
    logic [199:0] data_flat;
    logic [4:0]   elem_cnt;
    logic         busy;
    logic         done;
    logic         dim_err;

    typedef struct {
        logic [2:0]   idx;
        logic [2:0]   row;
        logic [2:0]   col;
        logic [199:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks  = 0;
    int         errors  = 0;
    int         exp_ptr = 0;
    logic [7:0] stim [25];
    logic       prev_wr = 1'b0;

    always #5 clk = ~clk;

    matrix_write_assembler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .row_in     (row_in),
        .col_in     (col_in),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .target_idx (target_idx),
        .write_row  (write_row),
        .write_col  (write_col),
        .data_flat  (data_flat),
        .elem_cnt   (elem_cnt),
        .busy       (busy),
        .done       (done),
        .dim_err    (dim_err)
    );

    // Scoreboard: every wr_en pops one expected write.
    always @(negedge clk) begin
        if (prev_wr) begin
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL done_after_wr: got %b expected 1", done);
            end
        end
        if (wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wr_en: got write to idx %0d expected none", target_idx);
            end else begin
                mon_e = exp_q.pop_front();
                if ({target_idx, write_row, write_col} !== {mon_e.idx, mon_e.row, mon_e.col}) begin
                    errors++;
                    $display("FAIL wr_header: got idx=%0d row=%0d col=%0d expected idx=%0d row=%0d col=%0d",
                             target_idx, write_row, write_col, mon_e.idx, mon_e.row, mon_e.col);
                end
                checks++;
                if (data_flat !== mon_e.data) begin
                    errors++;
                    $display("FAIL wr_data: got %h expected %h", data_flat, mon_e.data);
                end
            end
        end
        prev_wr = (wr_en === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one element and wait (bounded) for it to be accepted.
    task automatic push_elem(input logic [7:0] v);
        bit hs;
        in_valid = 1'b1;
        in_data  = v;
        hs = 1'b0;
        for (int cyc = 0; cyc < 20 && !hs; cyc++) begin
            hs = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got in_ready=%b expected 1", in_ready);
        end
    endtask

    // n_abort < 0 loads the full matrix; otherwise aborts after n_abort elements.
    // gap inserts an idle cycle with a stray start pulse before each element.
    task automatic send_matrix(input int r, input int c, input int n_abort, input bit gap);
        int   total;
        int   n;
        exp_t e;
        total = r * c;
        n = (n_abort < 0) ? total : n_abort;
        start  = 1'b1;
        row_in = r[2:0];
        col_in = c[2:0];
        tick();
        start = 1'b0;
        checks++;
        if ({busy, in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL load_entry: got busy=%b in_ready=%b expected 1 1", busy, in_ready);
        end
        if (n_abort < 0) begin
            e.idx  = exp_ptr[2:0];
            e.row  = r[2:0];
            e.col  = c[2:0];
            e.data = '0;
            for (int k = 0; k < total; k++) e.data[k*8 +: 8] = stim[k];
            exp_q.push_back(e);
            exp_ptr = (exp_ptr + 1) % 8;
        end
        for (int k = 0; k < n; k++) begin
            if (gap) begin
                start  = 1'b1;
                row_in = 3'd1;
                col_in = 3'd1;
                tick();
                start = 1'b0;
            end
            push_elem(stim[k]);
        end
        if (n_abort >= 0) begin
            abort    = 1'b1;
            in_valid = 1'b1;
            in_data  = 8'hEE;
            tick();
            abort    = 1'b0;
            in_valid = 1'b0;
            checks++;
            if ({busy, in_ready, wr_en, elem_cnt} !== {3'b000, 5'(n_abort)}) begin
                errors++;
                $display("FAIL abort_state: got busy=%b in_ready=%b wr_en=%b elem_cnt=%0d expected 0 0 0 %0d",
                         busy, in_ready, wr_en, elem_cnt, n_abort);
            end
            tick();
        end else begin
            checks++;
            if (wr_en !== 1'b1) begin
                errors++;
                $display("FAIL wr_latency: got wr_en=%b expected 1 one cycle after last handshake", wr_en);
            end
            tick();
            checks++;
            if ({done, busy, elem_cnt} !== {2'b10, 5'(total)}) begin
                errors++;
                $display("FAIL commit_exit: got done=%b busy=%b elem_cnt=%0d expected 1 0 %0d",
                         done, busy, elem_cnt, total);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({wr_en, in_ready, busy, done, dim_err, target_idx, elem_cnt, write_row, write_col}
                !== {5'b00000, 3'd0, 5'd0, 3'd1, 3'd1}) begin
            errors++;
            $display("FAIL reset_outputs: got wr=%b rdy=%b busy=%b done=%b derr=%b idx=%0d cnt=%0d row=%0d col=%0d expected 0 0 0 0 0 0 0 1 1",
                     wr_en, in_ready, busy, done, dim_err, target_idx, elem_cnt, write_row, write_col);
        end
        checks++;
        if (data_flat !== 200'd0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", data_flat);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        stim[0] = 8'h01; stim[1] = 8'h02; stim[2] = 8'hFB;
        stim[3] = 8'h04; stim[4] = 8'h05; stim[5] = 8'h06;
        send_matrix(2, 3, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 9; i++) begin
            stim[0] = 8'(8'h10 + i);
            send_matrix(1, 1, -1, 1'b0);
        end
    endtask

    task automatic test_dim_err();
        int r;
        int c;
        for (int i = 0; i < 2; i++) begin
            r = (i == 0) ? 0 : 6;
            c = (i == 0) ? 3 : 2;
            start  = 1'b1;
            row_in = r[2:0];
            col_in = c[2:0];
            tick();
            start = 1'b0;
            checks++;
            if ({dim_err, busy, in_ready} !== 3'b100) begin
                errors++;
                $display("FAIL dim_err_pulse: got dim_err=%b busy=%b in_ready=%b expected 1 0 0 (row=%0d col=%0d)",
                         dim_err, busy, in_ready, r, c);
            end
            tick();
            checks++;
            if ({dim_err, busy} !== 2'b00) begin
                errors++;
                $display("FAIL dim_err_clear: got dim_err=%b busy=%b expected 0 0", dim_err, busy);
            end
        end
        // Slot allocation must be unaffected: next write uses the modelled pointer.
        stim[0] = 8'h5A;
        send_matrix(1, 1, -1, 1'b0);
    endtask

    task automatic test_full_gapped();
        for (int k = 0; k < 25; k++) stim[k] = 8'(8'h80 + 3 * k);
        send_matrix(5, 5, -1, 1'b1);
    endtask

    task automatic test_abort();
        for (int k = 0; k < 9; k++) stim[k] = 8'(8'h30 + k);
        send_matrix(3, 3, 4, 1'b0);
        stim[0] = 8'hAA;
        stim[1] = 8'hBB;
        send_matrix(1, 2, -1, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        start  = 1'b1;
        row_in = 3'd4;
        col_in = 3'd4;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) push_elem(8'(8'hC0 + k));
        rst_n = 1'b0;
        exp_ptr = 0;
        #1;
        checks++;
        if ({wr_en, in_ready, busy, done, dim_err, target_idx, elem_cnt, write_row, write_col}
                !== {5'b00000, 3'd0, 5'd0, 3'd1, 3'd1}) begin
            errors++;
            $display("FAIL midload_reset: got wr=%b rdy=%b busy=%b done=%b derr=%b idx=%0d cnt=%0d row=%0d col=%0d expected 0 0 0 0 0 0 0 1 1",
                     wr_en, in_ready, busy, done, dim_err, target_idx, elem_cnt, write_row, write_col);
        end
        checks++;
        if (data_flat !== 200'd0) begin
            errors++;
            $display("FAIL midload_reset_data: got %h expected 0", data_flat);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        stim[0] = 8'h77;
        send_matrix(1, 1, -1, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        row_in   = 3'd0;
        col_in   = 3'd0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_basic();
        test_back_to_back();
        test_dim_err();
        test_full_gapped();
        test_abort();
        test_reset_mid_load();
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: got %0d writes outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_write_assembler.md
Name: matrix_write_assembler

Overview:
Serial-to-parallel front end for the multi-matrix storage write port. It accepts a matrix dimension pair, then row*col signed elements one at a time over a valid/ready handshake, and zero-fills unused slots. It then issues a single-cycle parallel write (wr_en, target_idx, write_row, write_col, 25 data words) to storage. Target indices are allocated round-robin, so the input/UART path never tracks storage slots.

Parameters:
DATA_WIDTH, 8, element width (two's complement, passed through unmodified)
MAX_SIZE, 5, maximum rows/cols; buffer depth is MAX_SIZE*MAX_SIZE = 25
MATRIX_NUM, 8, number of global storage slots; allocation wraps modulo this
MATRIX_IDX_W, 3, width of target_idx

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  begin a new matrix; sampled only in IDLE
row_in  input  3  row count, sampled with start
col_in  input  3  column count, sampled with start
abort  input  1  cancel the matrix being loaded
in_valid  input  1  element valid
in_data  input  DATA_WIDTH  element value, row-major order
in_ready  output  1  element accepted when in_valid & in_ready
wr_en  output  1  one-cycle write strobe to storage
target_idx  output  MATRIX_IDX_W  global slot being written
write_row  output  3  latched row count
write_col  output  3  latched column count
data_flat  output  25*DATA_WIDTH  element k on bits [k*DATA_WIDTH +: DATA_WIDTH]
elem_cnt  output  5  elements accepted so far in current matrix
busy  output  1  high in LOAD and COMMIT
done  output  1  one-cycle pulse the cycle after wr_en
dim_err  output  1  one-cycle pulse on start with illegal dimensions

Behaviour:
- Reset (async, rst_n=0): state IDLE. wr_en, in_ready, busy, done, dim_err = 0. target_idx, alloc_ptr, elem_cnt = 0. write_row, write_col = 1. data_flat = 0. Reset in any state discards a partial matrix with no write.
- State IDLE:
  - in_ready=0; in_valid is ignored.
  - start with row_in and col_in both in 1..MAX_SIZE: latch write_row/write_col, compute total = row_in*col_in (5 bits), clear all 25 buffer words to 0, elem_cnt=0, go to LOAD.
  - start with either dimension 0 or >MAX_SIZE: dim_err=1 for one cycle, stay IDLE, buffer untouched.
- State LOAD:
  - in_ready=1, busy=1.
  - Each handshake writes in_data to buffer[elem_cnt] and increments elem_cnt.
  - The handshake with elem_cnt==total-1 moves to COMMIT; in_ready is 0 from the next cycle.
  - abort=1: go to IDLE with no write; alloc_ptr unchanged. Abort takes priority over a same-cycle handshake, and that element is dropped.
  - start in LOAD is ignored.
- State COMMIT (exactly one cycle):
  - wr_en=1, target_idx=alloc_ptr; write_row, write_col and data_flat are stable.
  - Next cycle: state IDLE, done=1, alloc_ptr=(alloc_ptr+1) mod MATRIX_NUM (7 wraps to 0). abort is ignored in COMMIT.
- Latency: wr_en asserts the cycle after the final element handshake. Minimum back-to-back matrix time is total+2 cycles (start, total elements, commit).
- Outputs write_row, write_col, data_flat and target_idx hold their last committed values in IDLE until the next legal start. data_flat clears at that start.
- Slots in data_flat with index >= total are always 0.
- Assembler buffer is the only memory; storage-side registration and indexing belong to storage.

Test Plan:
- Reset then start row=2 col=3; send 01,02,FB,04,05,06 at one per cycle -> wr_en high one cycle after the 6th handshake with target_idx=0, write_row=2, write_col=3, words 0..5 = 01,02,FB,04,05,06, words 6..24 = 0; done on the next cycle.
- Eight consecutive 1x1 matrices with values 10..17 -> target_idx sequence 0..7; a ninth matrix writes target_idx=0 (wrap).
- Start row=0 col=3, then start row=6 col=2 -> dim_err pulses each time, busy stays 0, no wr_en, alloc_ptr unchanged.
- 5x5 load with in_valid toggling every other cycle -> exactly 25 elements captured in order, wr_en once, elem_cnt reaches 25; start pulses mid-load are ignored.
- 3x3 load, abort after 4 elements -> no wr_en, state IDLE; next 1x2 matrix gets the same target_idx as the aborted one, and stale words 2..8 read 0.
- rst_n low mid-LOAD of a 4x4 after 7 elements -> all outputs at reset values immediately; no wr_en ever issued for that matrix.
